// File: rtl/pcie_fifo_pkg.sv
// pcie_fifo_pkg
//   Shared defaults for the PCIe transaction-layer FIFO and its RAM:
//   data/address widths, almost-full/almost-empty thresholds, and the
//   helper that sizes the occupancy counter.
package pcie_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 12;
   localparam int DEF_ADDR_WIDTH = 3;
   localparam int DEF_AF_THRESH  = 6;
   localparam int DEF_AE_THRESH  = 2;

   // The count must represent 0..DEPTH inclusive, so it needs one bit more
   // than the pointers.
   function automatic int cnt_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/fifo_dpram_param.sv
// fifo_dpram_param
//   Single-clock dual-port RAM: one write port, one registered read port.
//   Ports:
//     clk, reset            clock; reset clears only the read register
//     i_wr_en/addr/data     write port
//     i_rd_en/addr          read request, data appears one cycle later
//     o_rd_data             registered read data, held when i_rd_en=0
//   Reading and writing the same address in one cycle returns the old
//   contents (read-before-write), which the FIFO relies on when full.
module fifo_dpram_param
   import pcie_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
   logic [DATA_WIDTH-1:0] r_rd_data;

   // Storage is never cleared; only the output register is.
   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
   end

   // Non-blocking read of r_mem samples the pre-write value.
   always_ff @(posedge clk) begin
      if (reset)        r_rd_data <= '0;
      else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pcie_fifo_param.sv
// pcie_fifo_param
//   Parametrised synchronous FIFO for the PCIe transaction-layer queues.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     data_in, push, pop    write data and requests
//     data_out, valid_out   registered read data, valid the cycle after a pop
//     full, empty           count == DEPTH / count == 0
//     almost_full/empty     count >= AF_THRESH / count <= AE_THRESH
//     count                 occupancy 0..DEPTH
//     overflow_err          pulse the cycle after a rejected push
//     underflow_err         pulse the cycle after a rejected pop
//   All outputs come from registers (or decodes of them); push/pop never
//   reach an output combinationally.
module pcie_fifo_param
   import pcie_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int AF_THRESH  = DEF_AF_THRESH,
   parameter int AE_THRESH  = DEF_AE_THRESH
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [DATA_WIDTH-1:0]              data_in,
   input  logic                               push,
   input  logic                               pop,
   output logic [DATA_WIDTH-1:0]              data_out,
   output logic                               valid_out,
   output logic                               full,
   output logic                               empty,
   output logic                               almost_full,
   output logic                               almost_empty,
   output logic [cnt_width(ADDR_WIDTH)-1:0]   count,
   output logic                               overflow_err,
   output logic                               underflow_err
);

   localparam int CW    = cnt_width(ADDR_WIDTH);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_valid, r_ovf, r_unf;
   logic                  w_full, w_empty, w_pop_ok, w_push_ok;

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);

   // A pop on an empty FIFO is refused even if a push arrives with it:
   // there is no write-to-read bypass. A push on a full FIFO is fine as
   // long as a pop frees the slot in the same cycle.
   assign w_pop_ok  = pop & ~w_empty;
   assign w_push_ok = push & (~w_full | w_pop_ok);

   fifo_dpram_param #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk       (clk),
      .reset     (reset),
      .i_wr_en   (w_push_ok & ~reset),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (data_in),
      .i_rd_en   (w_pop_ok & ~reset),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (data_out)
   );

   // DEPTH is a power of two, so pointer wrap is plain binary overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
         r_valid <= w_pop_ok;
         r_ovf   <= push & ~w_push_ok;
         r_unf   <= pop & ~w_pop_ok;
      end
   end

   assign valid_out     = r_valid;
   assign full          = w_full;
   assign empty         = w_empty;
   assign almost_full   = (r_count >= CW'(AF_THRESH));
   assign almost_empty  = (r_count <= CW'(AE_THRESH));
   assign count         = r_count;
   assign overflow_err  = r_ovf;
   assign underflow_err = r_unf;

endmodule

// File: tb/tb_pcie_fifo_param.sv
// tb_pcie_fifo_param
//   Queue-based reference model checked against the FIFO on every falling
//   edge, plus hand-computed literal checks at the interesting points.
module tb_pcie_fifo_param;
   import pcie_fifo_pkg::*;

   localparam int DW    = 12;
   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;
   localparam int AF    = 6;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] data_in = '0;
   logic          push = 1'b0, pop = 1'b0;
   logic [DW-1:0] data_out;
   logic          valid_out, full, empty, almost_full, almost_empty;
   logic [AW:0]   count;
   logic          overflow_err, underflow_err;

   int n_chk = 0, n_fail = 0;
   bit chk_en = 1'b0;

   pcie_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .push(push), .pop(pop),
      .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   // Reference model: the FIFO is just a queue with acceptance rules.
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_dout = '0;
   bit            m_valid = 0, m_ovf = 0, m_unf = 0;

   always @(posedge clk) begin
      bit pok, wok;
      if (reset) begin
         q.delete();
         m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
      end else begin
         pok = pop && (q.size() > 0);
         wok = push && ((q.size() < DEPTH) || pok);
         if (pok) m_dout = q.pop_front();
         if (wok) q.push_back(data_in);
         m_valid = pok;
         m_ovf   = push && !wok;
         m_unf   = pop && !pok;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      int sz;
      if (chk_en) begin
         sz = q.size();
         chk("m.count",    32'(count),         32'(sz));
         chk("m.empty",    32'(empty),         32'(sz == 0));
         chk("m.full",     32'(full),          32'(sz == DEPTH));
         chk("m.afull",    32'(almost_full),   32'(sz >= AF));
         chk("m.aempty",   32'(almost_empty),  32'(sz <= AE));
         chk("m.valid",    32'(valid_out),     32'(m_valid));
         chk("m.dout",     32'(data_out),      32'(m_dout));
         chk("m.ovf",      32'(overflow_err),  32'(m_ovf));
         chk("m.unf",      32'(underflow_err), 32'(m_unf));
      end
   end

   // Drive one cycle; returns at the following falling edge with outputs settled.
   task automatic cyc(input bit p, input bit r, input logic [DW-1:0] d);
      push = p; pop = r; data_in = d;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      // 1. reset then idle
      reset = 1'b1;
      cyc(0, 0, '0);
      chk_en = 1'b1;
      reset = 1'b0;
      cyc(0, 0, '0);
      chk("rst.count", 32'(count), 0);
      chk("rst.empty", 32'(empty), 1);
      chk("rst.aempty", 32'(almost_empty), 1);
      chk("rst.full", 32'(full), 0);
      chk("rst.valid", 32'(valid_out), 0);
      chk("rst.dout", 32'(data_out), 0);

      // 2. fill
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 0, DW'(i));
         if (i == 5) chk("fill.af5", 32'(almost_full), 0);
         if (i == 6) chk("fill.af6", 32'(almost_full), 1);
         if (i == 7) chk("fill.full7", 32'(full), 0);
      end
      chk("fill.full", 32'(full), 1);
      chk("fill.count", 32'(count), 8);
      cyc(1, 0, 12'hAAA);
      chk("ovf.pulse", 32'(overflow_err), 1);
      chk("ovf.count", 32'(count), 8);
      cyc(0, 0, '0);
      chk("ovf.clear", 32'(overflow_err), 0);

      // 3. drain
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 1, '0);
         chk("drain.dout", 32'(data_out), 32'(i));
         chk("drain.valid", 32'(valid_out), 1);
         if (i == 5) chk("drain.ae3", 32'(almost_empty), 0);
         if (i == 6) chk("drain.ae2", 32'(almost_empty), 1);
      end
      cyc(0, 1, '0);
      chk("unf.pulse", 32'(underflow_err), 1);
      chk("unf.valid", 32'(valid_out), 0);
      chk("unf.hold", 32'(data_out), 32'h008);
      cyc(0, 0, '0);
      chk("unf.clear", 32'(underflow_err), 0);

      // 4. wrap-around
      for (int r = 1; r <= 3; r++) begin
         for (int k = 0; k < 5; k++) cyc(1, 0, DW'(12'h100 * r + k));
         for (int k = 0; k < 5; k++) begin
            cyc(0, 1, '0);
            chk("wrap.dout", 32'(data_out), 32'(12'h100 * r + k));
         end
      end
      chk("wrap.count", 32'(count), 0);

      // 5a. push+pop while full
      for (int i = 0; i < 8; i++) cyc(1, 0, DW'(12'h200 + i));
      cyc(1, 1, 12'h123);
      chk("pp.full.dout", 32'(data_out), 32'h200);
      chk("pp.full.count", 32'(count), 8);
      chk("pp.full.ovf", 32'(overflow_err), 0);
      for (int i = 1; i <= 8; i++) begin
         cyc(0, 1, '0);
         chk("pp.full.drain", 32'(data_out), (i == 8) ? 32'h123 : 32'(12'h200 + i));
      end

      // 5b. push+pop while empty
      cyc(1, 1, 12'h0FF);
      chk("pp.empty.unf", 32'(underflow_err), 1);
      chk("pp.empty.count", 32'(count), 1);
      chk("pp.empty.valid", 32'(valid_out), 0);
      cyc(0, 1, '0);
      chk("pp.empty.dout", 32'(data_out), 32'h0FF);
      chk("pp.empty.valid2", 32'(valid_out), 1);

      // 6. reset mid-stream with pop
      for (int i = 0; i < 4; i++) cyc(1, 0, DW'(12'h300 + i));
      chk("mid.count4", 32'(count), 4);
      reset = 1'b1;
      cyc(0, 1, '0);
      reset = 1'b0;
      chk("mid.count", 32'(count), 0);
      chk("mid.empty", 32'(empty), 1);
      chk("mid.valid", 32'(valid_out), 0);
      cyc(1, 0, 12'h3C3);
      cyc(0, 1, '0);
      chk("mid.dout", 32'(data_out), 32'h3C3);
      chk("mid.valid2", 32'(valid_out), 1);

      // random traffic, model-checked every cycle
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         cyc(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), DW'($urandom));
      end
      reset = 1'b0;
      for (int i = 0; i < 10; i++) cyc(0, 1, '0);
      chk("end.empty", 32'(empty), 1);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
